// File: rtl/online_fir_ctrl.sv
// Sequencer for a tap-serial online-arithmetic FIR filter.
// One shared online CCM / online-adder datapath computes every tap product of a
// sample and accumulates it. This block drives the sample delay-line ring buffer,
// the coefficient select and the accumulator controls. It also handles the
// valid/ready handshakes on input samples and output results.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input sample handshake
//   wr_en, wr_ptr        delay-line write strobe and slot for the next sample
//   rd_ptr               delay-line slot feeding the CCM this cycle
//   coef_sel             tap index / CCM coefficient select
//   tap_zero             force this tap's product to zero (slot never written)
//   acc_clr, acc_en      accumulator clear (with tap 0) and accumulate enable
//   out_valid/out_ready  result handshake
module online_fir_ctrl #(
   parameter int unsigned  TAPS    = 8,
   parameter int unsigned  Stage   = 4,
   parameter int unsigned  ADD_LAT = 1,
   localparam int unsigned AW      = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW-1:0] coef_sel,
   output logic          tap_zero,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          out_valid,
   input  logic          out_ready
);

   // Stage only sizes the datapath; it has no effect on sequencing.
   if (TAPS < 2 || ADD_LAT > 3 || Stage < 1) begin : g_param_err
      $error("online_fir_ctrl: unsupported parameter set");
   end

   localparam int unsigned CW = $clog2(TAPS + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StMac   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StOut   = 2'd3;

   localparam logic [AW-1:0] TapLast   = AW'(TAPS - 1);
   localparam logic [AW:0]   TapsW     = (AW + 1)'(TAPS);
   localparam logic [CW-1:0] TapsC     = CW'(TAPS);
   localparam logic [1:0]    DrainLast = 2'((ADD_LAT == 0) ? 0 : ADD_LAT - 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] cur_ptr_q, cur_ptr_d;
   logic [AW-1:0] t_q, t_d;
   logic [CW-1:0] sample_cnt_q, sample_cnt_d;
   logic [1:0]    drain_q, drain_d;

   logic [CW-1:0] sample_incl;
   logic [AW-1:0] rd_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         cur_ptr_q    <= '0;
         t_q          <= '0;
         sample_cnt_q <= '0;
         drain_q      <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         cur_ptr_q    <= cur_ptr_d;
         t_q          <= t_d;
         sample_cnt_q <= sample_cnt_d;
         drain_q      <= drain_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      cur_ptr_d    = cur_ptr_q;
      t_d          = t_q;
      sample_cnt_d = sample_cnt_q;
      drain_d      = drain_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               cur_ptr_d = wr_ptr_q;
               t_d       = '0;
               state_d   = StMac;
            end
         end
         StMac: begin
            if (t_q == TapLast) begin
               t_d     = '0;
               drain_d = '0;
               state_d = (ADD_LAT == 0) ? StOut : StDrain;
            end else begin
               t_d = t_q + AW'(1);
            end
         end
         StDrain: begin
            if (drain_q == DrainLast) begin
               drain_d = '0;
               state_d = StOut;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         StOut: begin
            if (out_ready) begin
               // The slot advances only once the result is consumed, so the
               // sample just processed stays the newest entry until then.
               wr_ptr_d     = (wr_ptr_q == TapLast) ? '0 : wr_ptr_q + AW'(1);
               sample_cnt_d = (sample_cnt_q == TapsC) ? TapsC : sample_cnt_q + CW'(1);
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Samples held so far including the one being filtered, capped at TAPS.
   assign sample_incl = (sample_cnt_q == TapsC) ? TapsC : sample_cnt_q + CW'(1);

   // Newest sample first: walk the ring backwards from cur_ptr, wrapping below 0.
   always_comb begin
      if (t_q > cur_ptr_q) begin
         rd_raw = AW'({1'b0, cur_ptr_q} + TapsW - {1'b0, t_q});
      end else begin
         rd_raw = cur_ptr_q - t_q;
      end
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      wr_en     = in_valid & in_ready;
      wr_ptr    = wr_ptr_q;
      acc_en    = (state_q == StMac);
      acc_clr   = acc_en & (t_q == '0);
      coef_sel  = acc_en ? t_q : '0;
      rd_ptr    = acc_en ? rd_raw : '0;
      tap_zero  = acc_en & (CW'(t_q) >= sample_incl);
      out_valid = (state_q == StOut);
   end

endmodule

// File: tb/tb_online_fir_ctrl.sv
// Bench for online_fir_ctrl: instance A (TAPS=8, ADD_LAT=1), instance B (TAPS=5, ADD_LAT=0).
// The reference model tracks the ring write slot and the number of samples held,
// and it derives each cycle's expected outputs from the filter's sequencing rules.
module tb_online_fir_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   act = 1'b0;   // which instance the stimulus targets
   logic iv = 1'b0;
   logic orr = 1'b0;

   logic       a_in_valid, a_in_ready, a_wr_en, a_tap_zero, a_acc_clr, a_acc_en;
   logic       a_out_valid, a_out_ready;
   logic [2:0] a_wr_ptr, a_rd_ptr, a_coef_sel;
   logic       b_in_valid, b_in_ready, b_wr_en, b_tap_zero, b_acc_clr, b_acc_en;
   logic       b_out_valid, b_out_ready;
   logic [2:0] b_wr_ptr, b_rd_ptr, b_coef_sel;

   logic [14:0] obs_a, obs_b, obs, e;

   int total = 0;
   int bad = 0;
   int mwr[2];   // model: next write slot
   int mn[2];    // model: completed samples, saturating at TAPS

   always #5 clk = ~clk;

   assign a_in_valid  = (act == 1'b0) & iv;
   assign b_in_valid  = (act == 1'b1) & iv;
   assign a_out_ready = (act == 1'b0) & orr;
   assign b_out_ready = (act == 1'b1) & orr;

   assign obs_a = {a_in_ready, a_wr_en, a_acc_en, a_acc_clr, a_tap_zero, a_out_valid,
                   a_coef_sel, a_rd_ptr, a_wr_ptr};
   assign obs_b = {b_in_ready, b_wr_en, b_acc_en, b_acc_clr, b_tap_zero, b_out_valid,
                   b_coef_sel, b_rd_ptr, b_wr_ptr};
   assign obs   = act ? obs_b : obs_a;

   online_fir_ctrl #(.TAPS(8), .Stage(4), .ADD_LAT(1)) u_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (a_in_valid),
      .in_ready (a_in_ready),
      .wr_en    (a_wr_en),
      .wr_ptr   (a_wr_ptr),
      .rd_ptr   (a_rd_ptr),
      .coef_sel (a_coef_sel),
      .tap_zero (a_tap_zero),
      .acc_clr  (a_acc_clr),
      .acc_en   (a_acc_en),
      .out_valid(a_out_valid),
      .out_ready(a_out_ready)
   );

   online_fir_ctrl #(.TAPS(5), .Stage(4), .ADD_LAT(0)) u_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (b_in_valid),
      .in_ready (b_in_ready),
      .wr_en    (b_wr_en),
      .wr_ptr   (b_wr_ptr),
      .rd_ptr   (b_rd_ptr),
      .coef_sel (b_coef_sel),
      .tap_zero (b_tap_zero),
      .acc_clr  (b_acc_clr),
      .acc_en   (b_acc_en),
      .out_valid(b_out_valid),
      .out_ready(b_out_ready)
   );

   // Expected-vector builder in the same field order as obs.
   function automatic logic [14:0] vec(input bit ir, input bit we, input bit ae, input bit ac,
                                       input bit tz, input bit ov, input int cs, input int rp,
                                       input int wp);
      return {ir, we, ae, ac, tz, ov, 3'(cs), 3'(rp), 3'(wp)};
   endfunction

   // One full sample on instance sel. Entered just after a rising edge with the DUT
   // in IDLE. abort_t >= 0 asserts reset during that MAC tap and returns early.
   task automatic run_sample(input bit sel, input int gap, input int hold, input int abort_t);
      int taps, lat, cur, nincl;
      taps  = sel ? 5 : 8;
      lat   = sel ? 0 : 1;
      act   = sel;
      cur   = mwr[sel];
      nincl = (mn[sel] + 1 > taps) ? taps : mn[sel] + 1;
      orr   = (hold == 0);
      for (int g = 0; g < gap; g++) begin
         iv = 1'b0;
         @(negedge clk);
         e = vec(1, 0, 0, 0, 0, 0, 0, 0, mwr[sel]);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL idle_gap inst=%0d got=%h exp=%h", sel, obs, e);
         end
         @(posedge clk); #1;
      end
      iv = 1'b1;
      @(negedge clk);
      e = vec(1, 1, 0, 0, 0, 0, 0, 0, mwr[sel]);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL accept inst=%0d got=%h exp=%h", sel, obs, e);
      end
      @(posedge clk); #1 iv = 1'($urandom_range(0, 1));
      for (int t = 0; t < taps; t++) begin
         @(negedge clk);
         e = vec(0, 0, 1, t == 0, t >= nincl, 0, t, (cur - t + taps) % taps, mwr[sel]);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL mac inst=%0d t=%0d got=%h exp=%h", sel, t, obs, e);
         end
         if (t == abort_t) begin
            iv = 1'b0;
            rst_n = 1'b0;
            #1;
            e = vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
            total++;
            if (obs !== e) begin
               bad++;
               $display("FAIL reset_mid_mac got=%h exp=%h", obs, e);
            end
            mwr = '{0, 0};
            mn  = '{0, 0};
            return;
         end
         @(posedge clk); #1 iv = 1'($urandom_range(0, 1));
      end
      for (int d = 0; d < lat; d++) begin
         @(negedge clk);
         e = vec(0, 0, 0, 0, 0, 0, 0, 0, mwr[sel]);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL drain inst=%0d got=%h exp=%h", sel, obs, e);
         end
         @(posedge clk); #1 iv = 1'($urandom_range(0, 1));
      end
      for (int h = 0; h <= hold; h++) begin
         if (h == hold) orr = 1'b1;
         @(negedge clk);
         e = vec(0, 0, 0, 0, 0, 1, 0, 0, mwr[sel]);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL out inst=%0d h=%0d got=%h exp=%h", sel, h, obs, e);
         end
         @(posedge clk); #1 iv = 1'($urandom_range(0, 1));
      end
      iv = 1'b0;
      orr = 1'b0;
      mwr[sel] = (mwr[sel] + 1) % taps;
      mn[sel]  = (mn[sel] + 1 > taps) ? taps : mn[sel] + 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs_a !== e || obs_b !== e) begin
         bad++;
         $display("FAIL in_reset got_a=%h got_b=%h exp=%h", obs_a, obs_b, e);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      mwr = '{0, 0};
      mn  = '{0, 0};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (obs_a !== e || obs_b !== e) begin
            bad++;
            $display("FAIL post_reset c=%0d got_a=%h got_b=%h exp=%h", c, obs_a, obs_b, e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_first_sample();
      run_sample(1'b0, 0, 0, -1);
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 9; s++) run_sample(1'b0, 0, 0, -1);
   endtask

   task automatic test_backpressure();
      run_sample(1'b0, 1, 5, -1);
      run_sample(1'b0, 0, 0, -1);
   endtask

   task automatic test_reset_mid_mac();
      run_sample(1'b0, 0, 0, 3);
      @(posedge clk); #1 rst_n = 1'b1;
      run_sample(1'b0, 2, 0, -1);
      run_sample(1'b0, 0, 1, -1);
   endtask

   task automatic test_taps5();
      for (int s = 0; s < 8; s++) run_sample(1'b1, 0, 0, -1);
   endtask

   task automatic test_random_mix();
      for (int s = 0; s < 24; s++) begin
         run_sample(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end
   endtask

   initial begin
      test_reset();
      test_first_sample();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mac();
      test_taps5();
      test_random_mix();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
